// File: rtl/matmul_run_controller.sv
// Run sequencer for the multi-core matmul processor: reads the i/j/k dimensions,
// runs the requested cores until they all finish, then streams matrix C out.
module matmul_run_controller #(
  parameter int                NUM_CORES = 4,
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 16,
  parameter int                CYC_W     = 32,
  parameter logic [CYC_W-1:0]  TIMEOUT   = 32'd1_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           core_count,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [1:0]           status0,
  output logic [1:0]           status1,
  output logic [1:0]           status2,
  output logic [1:0]           status3,
  input  logic [NUM_CORES-1:0] end_process,
  output logic                 res_valid,
  output logic [DATA_W-1:0]    res_data,
  input  logic                 res_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CYC_W-1:0]     cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_DIM, S_RUN, S_DRAIN, S_FIN} state_t;
  typedef enum logic [1:0] {D_ADDR, D_READ, D_VALID} drain_t;

  state_t              state_q, state_d;
  drain_t              drain_q, drain_d;
  logic [1:0]          dim_cnt_q, dim_cnt_d;
  logic [2:0]          core_cnt_q, core_cnt_d;
  logic [7:0]          dim_i_q, dim_i_d;
  logic [7:0]          dim_j_q, dim_j_d;
  logic [ADDR_W-1:0]   base_c_q, base_c_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                err_q, err_d;
  logic [CYC_W-1:0]    cycle_count_q, cycle_count_d;

  logic [7:0]          dim_k;
  logic [15:0]         prod_ij, prod_jk, prod_ik;
  logic [16:0]         base_c_w;
  logic [17:0]         last_w;
  logic                addr_overflow;
  logic [CYC_W-1:0]    cyc_next;
  logic [NUM_CORES-1:0] mask_w, run_en_w;

  // k arrives on the read port in the last DIM cycle and is used directly.
  // last is one bit wider than the sums so an oversized C block cannot wrap into range.
  assign dim_k         = mem_rdata[7:0];
  assign prod_ij       = 16'(dim_i_q) * 16'(dim_j_q);
  assign prod_jk       = 16'(dim_j_q) * 16'(dim_k);
  assign prod_ik       = 16'(dim_i_q) * 16'(dim_k);
  assign base_c_w      = 17'd3 + 17'(prod_ij) + 17'(prod_jk);
  assign last_w        = 18'(base_c_w) + 18'(prod_ik) - 18'd1;
  assign addr_overflow = last_w > 18'((1 << ADDR_W) - 1);
  assign cyc_next      = cycle_count_q + CYC_W'(1);

  always_comb begin
    mask_w   = '0;
    run_en_w = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      if (3'(n) < core_cnt_q) begin
        mask_w[NUM_CORES-1-n] = 1'b1;
        run_en_w[n]           = (state_q == S_RUN);
      end
    end
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    drain_d       = drain_q;
    dim_cnt_d     = dim_cnt_q;
    core_cnt_d    = core_cnt_q;
    dim_i_d       = dim_i_q;
    dim_j_d       = dim_j_q;
    base_c_d      = base_c_q;
    last_d        = last_q;
    mem_addr_d    = mem_addr_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    err_d         = err_q;
    cycle_count_d = cycle_count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (core_count == 3'd0 || core_count > 3'(NUM_CORES)) begin
            err_d = 1'b1;
          end else begin
            err_d         = 1'b0;
            cycle_count_d = '0;
            core_cnt_d    = core_count;
            dim_cnt_d     = 2'd0;
            state_d       = S_DIM;
          end
        end
      end

      S_DIM: begin
        dim_cnt_d = dim_cnt_q + 2'd1;
        if (dim_cnt_q < 2'd2) mem_addr_d = mem_addr_q + ADDR_W'(1);
        case (dim_cnt_q)
          2'd1: dim_i_d = mem_rdata[7:0];
          2'd2: dim_j_d = mem_rdata[7:0];
          2'd3: begin
            base_c_d = base_c_w[ADDR_W-1:0];
            last_d   = last_w[ADDR_W-1:0];
            if (addr_overflow) begin
              err_d      = 1'b1;
              mem_addr_d = '0;
              state_d    = S_IDLE;
            end else if (prod_ik == 16'd0) begin
              state_d = S_FIN;
            end else begin
              state_d = S_RUN;
            end
          end
          default: ;
        endcase
      end

      S_RUN: begin
        cycle_count_d = cyc_next;
        if (end_process == mask_w) begin
          mem_addr_d = base_c_q;
          drain_d    = D_ADDR;
          state_d    = S_DRAIN;
        end else if (cyc_next == TIMEOUT) begin
          err_d      = 1'b1;
          mem_addr_d = '0;
          state_d    = S_IDLE;
        end
      end

      S_DRAIN: begin
        // Each word: address registered, read port latches it, then the word is presented.
        case (drain_q)
          D_ADDR: drain_d = D_READ;
          D_READ: begin
            res_data_d  = mem_rdata;
            res_valid_d = 1'b1;
            drain_d     = D_VALID;
          end
          default: begin
            if (res_ready) begin
              res_valid_d = 1'b0;
              if (mem_addr_q == last_q) begin
                state_d = S_FIN;
              end else begin
                mem_addr_d = mem_addr_q + ADDR_W'(1);
                drain_d    = D_ADDR;
              end
            end
          end
        endcase
      end

      S_FIN: begin
        mem_addr_d = '0;
        res_data_d = '0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q       <= S_IDLE;
      drain_q       <= D_ADDR;
      dim_cnt_q     <= 2'd0;
      core_cnt_q    <= 3'd0;
      dim_i_q       <= 8'd0;
      dim_j_q       <= 8'd0;
      base_c_q      <= '0;
      last_q        <= '0;
      mem_addr_q    <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      err_q         <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      dim_cnt_q     <= dim_cnt_d;
      core_cnt_q    <= core_cnt_d;
      dim_i_q       <= dim_i_d;
      dim_j_q       <= dim_j_d;
      base_c_q      <= base_c_d;
      last_q        <= last_d;
      mem_addr_q    <= mem_addr_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      err_q         <= err_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign status0     = {1'b0, run_en_w[0]};
  assign status1     = {1'b0, run_en_w[1]};
  assign status2     = {1'b0, run_en_w[2]};
  assign status3     = {1'b0, run_en_w[3]};
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign err         = err_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_matmul_run_controller.sv
// Self-checking bench for matmul_run_controller: directed and randomized jobs
// against a memory-map/job-level reference model.
module tb_matmul_run_controller;

  localparam int NC = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int CW = 32;
  localparam int TO = 50;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2:0]     core_count = 3'd0;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_rdata;
  logic [1:0]     status0, status1, status2, status3;
  logic [NC-1:0]  end_process = '0;
  logic           res_valid;
  logic [DW-1:0]  res_data;
  logic           res_ready = 1'b0;
  logic           busy, done, err;
  logic [CW-1:0]  cycle_count;
  logic [7:0]     status_all;

  int             checks = 0;
  int             failures = 0;
  int             exp_cyc = 0;
  logic [DW-1:0]  mem [256];

  matmul_run_controller #(
    .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .CYC_W(CW), .TIMEOUT(32'd50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .core_count(core_count),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .status0(status0), .status1(status1), .status2(status2), .status3(status3),
    .end_process(end_process), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .busy(busy), .done(done), .err(err),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Registered-read data memory file port.
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  assign status_all = {status3, status2, status1, status0};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] status_vec(input int cc);
    logic [7:0] v = '0;
    for (int n = 0; n < cc; n++) v[2*n +: 2] = 2'b01;
    return v;
  endfunction

  function automatic logic [3:0] mask_of(input int cc);
    logic [3:0] m = '0;
    for (int n = 0; n < cc; n++) m[3-n] = 1'b1;
    return m;
  endfunction

  task automatic fill_mem(input int ii, input int jj, input int kk);
    for (int a = 0; a < 256; a++) mem[a] = {8'($urandom), 8'(a)};
    mem[0] = {8'($urandom), 8'(ii)};
    mem[1] = {8'($urandom), 8'(jj)};
    mem[2] = {8'($urandom), 8'(kk)};
  endtask

  task automatic run_job(input int ii, input int jj, input int kk, input int cc,
                         input int run_len, input logic [3:0] partial,
                         input int stall_word, input int stall_len);
    int base, last, nwords, exp_run, idx, stalled, cyc;
    logic ovf, held;
    logic [DW-1:0] exp_q[$];
    fill_mem(ii, jj, kk);
    base   = 3 + ii*jj + jj*kk;
    nwords = ii*kk;
    last   = base + nwords - 1;
    ovf    = (last > 255);
    if (!ovf) for (int a = base; a <= last; a++) exp_q.push_back(mem[a]);

    @(negedge clk); start = 1'b1; core_count = 3'(cc); end_process = '0;
    @(negedge clk); start = 1'b0; core_count = 3'd0;
    check("dim_busy", busy, 1);
    check("dim_err_cleared", err, 0);
    check("dim_cyc_cleared", cycle_count, 0);
    check("dim_addr0", mem_addr, 0);
    @(negedge clk); check("dim_addr1", mem_addr, 1);
    @(negedge clk); check("dim_addr2", mem_addr, 2);
    @(negedge clk); check("dim_status_off", status_all, 0);
    @(negedge clk);

    if (ovf) begin
      check("ovf_err", err, 1);
      check("ovf_busy", busy, 0);
      check("ovf_status", status_all, 0);
      exp_cyc = 0;
      return;
    end
    if (nwords == 0) begin
      check("empty_done", done, 1);
      @(negedge clk);
      check("empty_idle", busy, 0);
      check("empty_cyc", cycle_count, 0);
      exp_cyc = 0;
      return;
    end

    exp_run = (run_len < TO) ? run_len : TO;
    for (int rc = 1; rc <= exp_run; rc++) begin
      if (rc > 1) @(negedge clk);
      if (rc == 1 || rc == exp_run) check("run_status", status_all, status_vec(cc));
      start = (rc == 2);
      end_process = (rc == run_len) ? mask_of(cc) : partial;
    end
    @(negedge clk); start = 1'b0; end_process = '0;

    if (run_len > TO) begin
      check("timeout_err", err, 1);
      check("timeout_busy", busy, 0);
      check("timeout_status", status_all, 0);
      check("timeout_cyc", cycle_count, TO);
      exp_cyc = TO;
      return;
    end

    check("drain_status_off", status_all, 0);
    check("drain_busy", busy, 1);
    check("drain_start_ignored", err, 0);
    check("run_cycles", cycle_count, run_len);
    idx = 0; stalled = 0; cyc = 0; held = 1'b0;
    res_ready = 1'($urandom_range(0, 1));
    while (idx < nwords && cyc < 2000) begin
      @(negedge clk); cyc++;
      if (held) check("stall_hold_valid", res_valid, 1);
      held = 1'b0;
      if (done) check("done_early", done, 0);
      if (res_valid) begin
        if (idx == stall_word && stalled < stall_len) begin
          check("stall_data", res_data, exp_q[idx]);
          res_ready = 1'b0;
          stalled++;
          held = 1'b1;
        end else begin
          check("word", res_data, exp_q[idx]);
          res_ready = 1'b1;
          idx++;
        end
      end else begin
        res_ready = 1'($urandom_range(0, 1));
      end
    end
    check("drain_words", idx, nwords);
    @(negedge clk); res_ready = 1'b0;
    check("fin_done", done, 1);
    check("fin_busy", busy, 1);
    check("fin_valid", res_valid, 0);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_cyc_held", cycle_count, run_len);
    check("idle_addr", mem_addr, 0);
    check("idle_res_data", res_data, 0);
    exp_cyc = run_len;
  endtask

  task automatic bad_start(input int cc);
    @(negedge clk); start = 1'b1; core_count = 3'(cc);
    @(negedge clk); start = 1'b0; core_count = 3'd0;
    check("bad_err", err, 1);
    check("bad_busy", busy, 0);
    check("bad_status", status_all, 0);
    check("bad_cyc_held", cycle_count, exp_cyc);
    @(negedge clk);
    check("bad_still_idle", busy, 0);
  endtask

  task automatic reset_mid_drain();
    int cyc;
    fill_mem(2, 2, 2);
    @(negedge clk); start = 1'b1; core_count = 3'd2;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 100) begin
      end_process = mask_of(2);
      @(negedge clk); cyc++;
    end
    check("rst_reached_drain", res_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_addr", mem_addr, 0);
    check("rst_status", status_all, 0);
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cyc", cycle_count, 0);
    rst_n = 1'b1; end_process = '0;
    exp_cyc = 0;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = '0;
    repeat (2) @(negedge clk);
    check("reset_addr", mem_addr, 0);
    check("reset_status", status_all, 0);
    check("reset_valid", res_valid, 0);
    check("reset_data", res_data, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_cyc", cycle_count, 0);
    rst_n = 1'b1;

    run_job(2, 2, 2, 1, 20, 4'b0000, -1, 0);
    run_job(2, 3, 2, 4, 12, 4'b1100, -1, 0);
    run_job(2, 2, 3, 2, 5, 4'b1110, -1, 0);
    bad_start(0);
    bad_start(5);
    run_job(1, 1, 1, 3, 3, 4'b0110, -1, 0);
    run_job(9, 9, 9, 2, 4, 4'b0100, 40, 3);
    run_job(10, 10, 10, 1, 4, 4'b0000, -1, 0);
    run_job(3, 2, 3, 3, 7, 4'b1100, 1, 5);
    run_job(2, 2, 2, 2, 60, 4'b1000, -1, 0);
    run_job(0, 4, 4, 1, 5, 4'b0000, -1, 0);
    for (int t = 0; t < 6; t++) begin
      int ri, rj, rk, rcc;
      ri  = $urandom_range(0, 5);
      rj  = $urandom_range(0, 5);
      rk  = $urandom_range(0, 5);
      rcc = $urandom_range(1, 4);
      run_job(ri, rj, rk, rcc, $urandom_range(1, 30),
              mask_of(rcc) ^ 4'(1 << $urandom_range(0, 3)),
              $urandom_range(0, 3), $urandom_range(0, 4));
    end
    reset_mid_drain();
    run_job(1, 2, 3, 4, 2, 4'b0111, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
